// File: rtl/light_sequencer_pkg.sv
// light_sequencer_pkg: shared game constants, light state encoding and duration helper.
package light_sequencer_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, GREEN = 2'd1, YELLOW = 2'd2, RED = 2'd3} state_t;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    function automatic logic [7:0] at_least_one(input logic [7:0] d);
        return d == 8'd0 ? 8'd1 : d;
    endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, loaded with seed on reset.
module lfsr16
    import light_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) q <= seed;
        else q <= {q[14:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/light_sequencer.sv
// light_sequencer: tick-timed GREEN/YELLOW/RED round sequencer with randomised GREEN length.
module light_sequencer
    import light_sequencer_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       tick,
    input  logic [7:0] green_min,
    input  logic [3:0] green_span,
    input  logic [3:0] yellow_len,
    input  logic [7:0] red_len,
    output logic       green,
    output logic       yellow,
    output logic       red,
    output logic       enable,
    output logic [1:0] phase,
    output logic [7:0] round_cnt
);
    state_t      state, nxt;
    logic [7:0]  timer, nxt_timer, gdur, dur;
    logic [8:0]  gsum;
    logic [15:0] lfsr;
    logic        expire;

    lfsr16 u_lfsr (.clk(clk), .rst(rst), .seed(SEED), .q(lfsr));

    always_comb begin
        gsum      = {1'b0, green_min} + {5'd0, lfsr[3:0] & green_span};
        gdur      = at_least_one(gsum[8] ? 8'hFF : gsum[7:0]);
        expire    = tick && timer == 8'd1;
        nxt       = stop ? IDLE :
                    state == IDLE ? (start ? GREEN : IDLE) :
                    !expire ? state :
                    state == GREEN ? YELLOW :
                    state == YELLOW ? RED : GREEN;
        dur       = nxt == GREEN ? gdur :
                    nxt == YELLOW ? at_least_one({4'd0, yellow_len}) : at_least_one(red_len);
        // every change of active phase reloads; otherwise count down on tick only
        nxt_timer = nxt == IDLE ? 8'd0 :
                    nxt != state ? dur :
                    tick ? timer - 8'd1 : timer;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state     <= IDLE;
            timer     <= 8'd0;
            green     <= 1'b0;
            yellow    <= 1'b0;
            red       <= 1'b0;
            enable    <= 1'b0;
            phase     <= 2'd0;
            round_cnt <= 8'd0;
        end else begin
            state     <= nxt;
            timer     <= nxt_timer;
            green     <= nxt == GREEN;
            yellow    <= nxt == YELLOW;
            red       <= nxt == RED;
            enable    <= nxt != IDLE;
            phase     <= nxt;
            round_cnt <= round_cnt + {7'd0, state == RED && nxt == GREEN};
        end
endmodule
